// File: rtl/prog_ctr_pkg.sv
// Shared constants and state type for the program-counter sequencer.
// Optional taken-branch counter is enabled by defining PROG_CTR_BRCOUNT_EN.
package prog_ctr_pkg;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned LUT_AW  = 5;
    localparam int unsigned BRCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/prog_ctr_if.sv
// Run/done handshake, decoder and branch-lookup signals of prog_ctr.
// BrCount exists only when PROG_CTR_BRCOUNT_EN is defined.
interface prog_ctr_if;
    import prog_ctr_pkg::*;

    logic              Start;
    logic [PC_W-1:0]   StartAddr;
    logic              Stall;
    logic              Halt;
    logic              BranchEn;
    logic              Cond;
    logic [LUT_AW-1:0] LutIdx;
    logic [PC_W-1:0]   Target;
    logic [LUT_AW-1:0] LutAddr;
    logic [PC_W-1:0]   PC;
    logic              Busy;
    logic              Done;
    logic              Fault;
`ifdef PROG_CTR_BRCOUNT_EN
    logic [BRCNT_W-1:0] BrCount;

    modport master (
        output Start, StartAddr, Stall, Halt, BranchEn, Cond, LutIdx, Target,
        input  LutAddr, PC, Busy, Done, Fault, BrCount
    );
    modport slave (
        input  Start, StartAddr, Stall, Halt, BranchEn, Cond, LutIdx, Target,
        output LutAddr, PC, Busy, Done, Fault, BrCount
    );
`else
    modport master (
        output Start, StartAddr, Stall, Halt, BranchEn, Cond, LutIdx, Target,
        input  LutAddr, PC, Busy, Done, Fault
    );
    modport slave (
        input  Start, StartAddr, Stall, Halt, BranchEn, Cond, LutIdx, Target,
        output LutAddr, PC, Busy, Done, Fault
    );
`endif

endinterface

// File: rtl/prog_ctr_pc_next.sv
// Combinational next-PC select (halt > taken branch > increment) and
// out-of-program fault detection against PROG_LEN.
module pc_next
    import prog_ctr_pkg::*;
#(
    parameter int unsigned PROG_LEN = 1024
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] target_i,
    input  logic            halt_i,
    input  logic            branch_en_i,
    input  logic            cond_i,
    output logic [PC_W-1:0] next_pc_o,
    output logic            taken_o,
    output logic            fault_o
);

    logic [PC_W-1:0] cand_pc;

    always_comb begin
        taken_o = branch_en_i & cond_i & ~halt_i;
        cand_pc = taken_o ? target_i : pc_i + PC_W'(1);
        // Widened compare so PROG_LEN = 2**PC_W never flags the 1023->0 wrap.
        fault_o   = ~halt_i && (32'(cand_pc) >= PROG_LEN);
        next_pc_o = (halt_i || fault_o) ? pc_i : cand_pc;
    end

endmodule

// File: rtl/prog_ctr.sv
// Program-counter sequencer: IDLE/LOAD/RUN/DONE control, PC and fault state.
// Define PROG_CTR_BRCOUNT_EN to add the saturating taken-branch counter.
module prog_ctr
    import prog_ctr_pkg::*;
#(
    parameter int unsigned PROG_LEN = 1024
) (
    input logic       Clk,
    input logic       Reset,
    prog_ctr_if.slave bus
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [PC_W-1:0] nxt_pc;
    logic            br_taken;
    logic            nxt_fault;
`ifdef PROG_CTR_BRCOUNT_EN
    logic [BRCNT_W-1:0] brcount_q, brcount_d;
`endif

    pc_next #(
        .PROG_LEN (PROG_LEN)
    ) u_pc_next (
        .pc_i        (pc_q),
        .target_i    (bus.Target),
        .halt_i      (bus.Halt),
        .branch_en_i (bus.BranchEn),
        .cond_i      (bus.Cond),
        .next_pc_o   (nxt_pc),
        .taken_o     (br_taken),
        .fault_o     (nxt_fault)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
`ifdef PROG_CTR_BRCOUNT_EN
        brcount_d = brcount_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                // Fault drops with Done as soon as a new run is accepted.
                if (bus.Start) begin
                    state_d = LOAD;
                    fault_d = 1'b0;
                end
            end
            LOAD: begin
                pc_d      = bus.StartAddr;
                fault_d   = 1'b0;
`ifdef PROG_CTR_BRCOUNT_EN
                brcount_d = '0;
`endif
                state_d   = RUN;
            end
            RUN: begin
                if (!bus.Stall) begin
                    pc_d = nxt_pc;
`ifdef PROG_CTR_BRCOUNT_EN
                    if (br_taken && (brcount_q != '1))
                        brcount_d = brcount_q + BRCNT_W'(1);
`endif
                    if (bus.Halt) begin
                        state_d = DONE;
                    end else if (nxt_fault) begin
                        fault_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            fault_q   <= 1'b0;
`ifdef PROG_CTR_BRCOUNT_EN
            brcount_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fault_q   <= fault_d;
`ifdef PROG_CTR_BRCOUNT_EN
            brcount_q <= brcount_d;
`endif
        end
    end

    assign bus.LutAddr = bus.LutIdx;
    assign bus.PC      = pc_q;
    assign bus.Busy    = (state_q == LOAD) || (state_q == RUN);
    assign bus.Done    = (state_q == DONE);
    assign bus.Fault   = fault_q;
`ifdef PROG_CTR_BRCOUNT_EN
    assign bus.BrCount = brcount_q;
`endif

endmodule

// File: tb/tb_prog_ctr.sv
// Self-checking bench for prog_ctr (PROG_LEN=128): directed scenarios then
// random stimulus against a behavioural model; honours PROG_CTR_BRCOUNT_EN.
module tb_prog_ctr;
    import prog_ctr_pkg::*;

    localparam int unsigned LEN = 128;

    typedef enum {M_IDLE, M_LOAD, M_RUN, M_DONE} mstate_t;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    prog_ctr_if bus();

    prog_ctr #(.PROG_LEN(LEN)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mstate_t     m_st  = M_IDLE;
    int unsigned m_pc  = 0;
    bit          m_flt = 1'b0;
    int unsigned m_brc = 0;

    logic [PC_W-1:0] lut [32];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the model, and compares after the edge.
    task automatic step(input bit rst_n, input bit start, input int unsigned saddr,
                        input bit stall, input bit halt, input bit br, input bit cond,
                        input int unsigned idx);
        int unsigned nxt;
        Reset         = rst_n;
        bus.Start     = start;
        bus.StartAddr = PC_W'(saddr);
        bus.Stall     = stall;
        bus.Halt      = halt;
        bus.BranchEn  = br;
        bus.Cond      = cond;
        bus.LutIdx    = LUT_AW'(idx);
        bus.Target    = lut[idx % 32];
        #1;
        check_eq("lut_addr", 32'(bus.LutAddr), idx % 32);

        if (!rst_n) begin
            m_st = M_IDLE; m_pc = 0; m_flt = 0; m_brc = 0;
        end else begin
            case (m_st)
                M_IDLE, M_DONE: if (start) begin m_st = M_LOAD; m_flt = 0; end
                M_LOAD: begin m_pc = saddr % 1024; m_flt = 0; m_brc = 0; m_st = M_RUN; end
                M_RUN: if (!stall) begin
                    if (halt) m_st = M_DONE;
                    else begin
                        if (br && cond) begin
                            nxt = int'(lut[idx % 32]);
                            if (m_brc < 65535) m_brc++;
                        end else nxt = (m_pc + 1) % 1024;
                        if (nxt >= LEN) begin m_flt = 1; m_st = M_DONE; end
                        else m_pc = nxt;
                    end
                end
                default: ;
            endcase
        end

        @(posedge Clk);
        #1;
        check_eq("pc", 32'(bus.PC), m_pc);
        check_eq("busy", 32'(bus.Busy), 32'(m_st == M_LOAD || m_st == M_RUN));
        check_eq("done", 32'(bus.Done), 32'(m_st == M_DONE));
        check_eq("fault", 32'(bus.Fault), 32'(m_flt));
`ifdef PROG_CTR_BRCOUNT_EN
        check_eq("brcount", 32'(bus.BrCount), m_brc);
`endif
    endtask

    task automatic idle_cyc(input bit start, input int unsigned saddr);
        step(1, start, saddr, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) lut[i] = PC_W'($urandom_range(0, LEN - 1));
        lut[5'h13] = PC_W'(6);
        lut[5]     = PC_W'(200);
        bus.Start = 0; bus.StartAddr = '0; bus.Stall = 0; bus.Halt = 0;
        bus.BranchEn = 0; bus.Cond = 0; bus.LutIdx = '0; bus.Target = '0;

        // Reset, then a plain run from address 6.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_pc", 32'(bus.PC), 0);
        check_eq("rst_busy", 32'(bus.Busy), 0);
        idle_cyc(1, 6);
        idle_cyc(0, 6);
        check_eq("entry_pc", 32'(bus.PC), 6);
        for (int i = 1; i <= 3; i++) begin
            idle_cyc(0, 6);
            check_eq("inc_pc", 32'(bus.PC), 32'(6 + i));
        end
        check_eq("run_busy", 32'(bus.Busy), 1);

        // Reset mid-run while stalled.
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        check_eq("midrst_pc", 32'(bus.PC), 0);
        check_eq("midrst_busy", 32'(bus.Busy), 0);
        check_eq("midrst_done", 32'(bus.Done), 0);

        // Taken branch from PC=40 via index 0x13.
        idle_cyc(1, 40);
        idle_cyc(0, 40);
        step(1, 0, 40, 0, 0, 1, 1, 5'h13);
        check_eq("br_pc", 32'(bus.PC), 6);
`ifdef PROG_CTR_BRCOUNT_EN
        check_eq("br_cnt", 32'(bus.BrCount), 1);
`endif
        step(1, 0, 0, 0, 1, 0, 0, 0);
        check_eq("halt_done", 32'(bus.Done), 1);

        // Not-taken branch, then stall holding halt+branch, then halt.
        idle_cyc(1, 40);
        idle_cyc(0, 40);
        step(1, 0, 40, 0, 0, 1, 0, 5'h13);
        check_eq("nt_pc", 32'(bus.PC), 41);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, 1, 1, 1, 5'h13);
            check_eq("stall_pc", 32'(bus.PC), 41);
            check_eq("stall_busy", 32'(bus.Busy), 1);
        end
        step(1, 0, 0, 0, 1, 0, 0, 0);
        check_eq("halt2_done", 32'(bus.Done), 1);
        check_eq("halt2_pc", 32'(bus.PC), 41);

        // Run off the end of the program.
        idle_cyc(1, 125);
        idle_cyc(0, 125);
        idle_cyc(0, 0);
        idle_cyc(0, 0);
        check_eq("end_pc", 32'(bus.PC), 127);
        idle_cyc(0, 0);
        check_eq("ovf_fault", 32'(bus.Fault), 1);
        check_eq("ovf_done", 32'(bus.Done), 1);
        check_eq("ovf_pc", 32'(bus.PC), 127);
        idle_cyc(1, 125);
        check_eq("reload_fault", 32'(bus.Fault), 0);
        check_eq("reload_done", 32'(bus.Done), 0);
        idle_cyc(0, 125);

        // Branch to an out-of-program target.
        step(1, 0, 0, 0, 0, 1, 1, 5);
        check_eq("brflt_fault", 32'(bus.Fault), 1);
        check_eq("brflt_pc", 32'(bus.PC), 125);
`ifdef PROG_CTR_BRCOUNT_EN
        check_eq("brflt_cnt", 32'(bus.BrCount), 1);
`endif

        // Random traffic; some lookup targets lie beyond the program.
        for (int i = 0; i < 32; i++)
            lut[i] = ($urandom_range(0, 9) == 0) ? PC_W'($urandom_range(LEN, 1023))
                                                 : PC_W'($urandom_range(0, LEN - 1));
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 15) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, LEN - 1),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 31));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
